// File: rtl/mem_port_arbiter.sv
// Two-way arbiter for the bridge's data-side port: the DCache path (C) and the uncached unit (U)
// take turns owning the port, and ownership is held until the downstream transaction completes.
module mem_port_arbiter #(
    parameter bit FIXED_PRIO = 1'b0,
    parameter int WDATA_W    = 128
) (
    input  logic               clk,
    input  logic               resetn,

    input  logic               c_rd_req,
    input  logic [2:0]         c_rd_type,
    input  logic [31:0]        c_rd_addr,
    output logic               c_rd_rdy,
    output logic               c_ret_valid,
    output logic               c_ret_last,
    output logic [31:0]        c_ret_data,
    input  logic               c_wr_req,
    input  logic [2:0]         c_wr_type,
    input  logic [31:0]        c_wr_addr,
    input  logic [3:0]         c_wr_wstrb,
    input  logic [WDATA_W-1:0] c_wr_data,
    output logic               c_wr_rdy,

    input  logic               u_rd_req,
    input  logic [2:0]         u_rd_type,
    input  logic [31:0]        u_rd_addr,
    output logic               u_rd_rdy,
    output logic               u_ret_valid,
    output logic               u_ret_last,
    output logic [31:0]        u_ret_data,
    input  logic               u_wr_req,
    input  logic [2:0]         u_wr_type,
    input  logic [31:0]        u_wr_addr,
    input  logic [3:0]         u_wr_wstrb,
    input  logic [WDATA_W-1:0] u_wr_data,
    output logic               u_wr_rdy,

    output logic               dn_rd_req,
    output logic [2:0]         dn_rd_type,
    output logic [31:0]        dn_rd_addr,
    input  logic               dn_rd_rdy,
    input  logic               dn_ret_valid,
    input  logic               dn_ret_last,
    input  logic [31:0]        dn_ret_data,
    output logic               dn_wr_req,
    output logic [2:0]         dn_wr_type,
    output logic [31:0]        dn_wr_addr,
    output logic [3:0]         dn_wr_wstrb,
    output logic [WDATA_W-1:0] dn_wr_data,
    input  logic               dn_wr_rdy,

    output logic               owner,
    output logic               busy,
    output logic               err_stray_ret,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RD_WAIT = 2'd2,
        S_WR_WAIT = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next_state;
    logic   r_owner;
    logic   r_last_grant;
    logic   r_seen_busy;
    logic   r_err_stray;

    logic   w_c_any;
    logic   w_u_any;
    logic   w_grant;
    logic   w_own_rd;
    logic   w_own_wr;
    logic   w_rd_acc;
    logic   w_wr_acc;

    assign w_c_any  = c_rd_req | c_wr_req;
    assign w_u_any  = u_rd_req | u_wr_req;
    // Tie: U under fixed priority, otherwise whoever did not win last time.
    assign w_grant  = (w_c_any & w_u_any) ? (FIXED_PRIO ? 1'b1 : ~r_last_grant) : w_u_any;
    assign w_own_rd = r_owner ? u_rd_req : c_rd_req;
    assign w_own_wr = r_owner ? u_wr_req : c_wr_req;
    assign w_rd_acc = (r_state == S_ISSUE) & w_own_rd & dn_rd_rdy;
    assign w_wr_acc = (r_state == S_ISSUE) & w_own_wr & dn_wr_rdy;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state      <= S_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_seen_busy  <= 1'b0;
            r_err_stray  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_IDLE) && (w_c_any || w_u_any)) begin
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
            end
            // The bridge drops wr_rdy after accepting and raises it again once bresp is back.
            if (w_wr_acc)
                r_seen_busy <= 1'b0;
            else if ((r_state == S_WR_WAIT) && !dn_wr_rdy)
                r_seen_busy <= 1'b1;
            if (dn_ret_valid && (r_state != S_RD_WAIT))
                r_err_stray <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_c_any || w_u_any)
                    w_next_state = S_ISSUE;
            end
            S_ISSUE: begin
                if (w_rd_acc)
                    w_next_state = S_RD_WAIT;
                else if (w_wr_acc)
                    w_next_state = S_WR_WAIT;
                else if (!w_own_rd && !w_own_wr)
                    w_next_state = S_IDLE;
            end
            S_RD_WAIT: begin
                if (dn_ret_valid && dn_ret_last)
                    w_next_state = S_IDLE;
            end
            S_WR_WAIT: begin
                if (r_seen_busy && dn_wr_rdy)
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        dn_rd_req   = 1'b0;
        dn_wr_req   = 1'b0;
        c_rd_rdy    = 1'b0;
        u_rd_rdy    = 1'b0;
        c_wr_rdy    = 1'b0;
        u_wr_rdy    = 1'b0;
        c_ret_valid = 1'b0;
        u_ret_valid = 1'b0;

        dn_rd_type  = r_owner ? u_rd_type  : c_rd_type;
        dn_rd_addr  = r_owner ? u_rd_addr  : c_rd_addr;
        dn_wr_type  = r_owner ? u_wr_type  : c_wr_type;
        dn_wr_addr  = r_owner ? u_wr_addr  : c_wr_addr;
        dn_wr_wstrb = r_owner ? u_wr_wstrb : c_wr_wstrb;
        dn_wr_data  = r_owner ? u_wr_data  : c_wr_data;

        c_ret_last  = dn_ret_last;
        u_ret_last  = dn_ret_last;
        c_ret_data  = dn_ret_data;
        u_ret_data  = dn_ret_data;

        if (r_state == S_ISSUE) begin
            dn_rd_req = w_own_rd;
            dn_wr_req = w_own_wr;
            c_rd_rdy  = ~r_owner & c_rd_req & dn_rd_rdy;
            u_rd_rdy  =  r_owner & u_rd_req & dn_rd_rdy;
            c_wr_rdy  = ~r_owner & c_wr_req & dn_wr_rdy;
            u_wr_rdy  =  r_owner & u_wr_req & dn_wr_rdy;
        end
        if (r_state == S_RD_WAIT) begin
            c_ret_valid = ~r_owner & dn_ret_valid;
            u_ret_valid =  r_owner & dn_ret_valid;
        end

        owner         = r_owner;
        busy          = (r_state != S_IDLE);
        err_stray_ret = r_err_stray;
        dbg_state     = r_state;
    end

endmodule
